// File: rtl/imsic_setipnum_queue.sv
// imsic_setipnum_queue: buffered IMSIC MSI write front end.
// Decodes seteipnum_le/be writes to each hart's M and S/VS interrupt-file
// pages. Valid identities are queued per file and handed to the file over
// valid/ready.
// Optional: define IMSIC_SETIPNUM_DROP_CNT_EN for per-file 16-bit drop
// counters at page offset 0x008.

// Per-file identity FIFO. The count is one bit wider than the pointers so
// that full and empty can be told apart.
module imsic_setipnum_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;
    logic             w_push_ok;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop     = o_valid & i_ready;
    // A push into a full FIFO still lands when the head leaves this cycle.
    assign w_push_ok = i_push & (~o_full | w_pop);

    // Storage write; contents need no reset because the count gates them.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule

module imsic_setipnum_queue #(
    parameter int                NR_IMSICS             = 1,
    parameter int                NR_VS_FILES_PER_IMSIC = 0,
    parameter int                NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
    parameter int                NR_SRC                = 64,
    parameter int                SRC_W                 = $clog2(NR_SRC),
    parameter int                FIFO_DEPTH            = 4,
    parameter int                ADDR_W                = 32,
    parameter logic [ADDR_W-1:0] IMSIC_M_BASE_ADDR     = 32'h24000000,
    parameter logic [ADDR_W-1:0] IMSIC_S_BASE_ADDR     = 32'h28000000
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_en,
    input  logic                                           i_we,
    input  logic [ADDR_W-1:0]                              i_addr,
    input  logic [31:0]                                    i_wdata,
    output logic [31:0]                                    o_rdata,
    output logic                                           o_rvalid,
    output logic [NR_IMSICS*NR_INTP_FILES-1:0][SRC_W-1:0]  o_setipnum,
    output logic [NR_IMSICS*NR_INTP_FILES-1:0]             o_setipnum_valid,
    input  logic [NR_IMSICS*NR_INTP_FILES-1:0]             i_setipnum_ready,
    output logic                                           o_drop
);
    localparam int NF = NR_IMSICS * NR_INTP_FILES;

    logic [11:0]   w_off;
    logic [31:0]   w_id;
    logic          w_set;
    logic          w_rd;
    logic [NF-1:0] w_hit;
    logic [NF-1:0] w_push;
    logic [NF-1:0] w_full;
    logic [NF-1:0] w_drop;
    logic [31:0]   w_rdata_nxt;
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_drop;

    assign w_off = i_addr[11:0];
    // Offset 0x004 carries the identity byte-reversed.
    assign w_id  = (w_off == 12'h004) ?
                   {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]} : i_wdata;
    // Out-of-range identities are discarded quietly, never counted as drops.
    assign w_set = i_en & i_we & ((w_off == 12'h000) | (w_off == 12'h004)) &
                   (w_id != 32'd0) & (w_id < 32'(NR_SRC));
    assign w_rd  = i_en & ~i_we;

    for (genvar f = 0; f < NF; f++) begin : g_file
        localparam int H = f / NR_INTP_FILES;
        localparam int K = f % NR_INTP_FILES;
        // M pages are one per hart; S/VS pages pack (NR_INTP_FILES-1) per hart.
        localparam logic [ADDR_W-1:0] PAGE = (K == 0) ?
            ADDR_W'(IMSIC_M_BASE_ADDR + H * 32'h1000) :
            ADDR_W'(IMSIC_S_BASE_ADDR + (H * (NR_INTP_FILES - 1) + K - 1) * 32'h1000);

        assign w_hit[f]  = (i_addr[ADDR_W-1:12] == PAGE[ADDR_W-1:12]);
        assign w_push[f] = w_set & w_hit[f];
        assign w_drop[f] = w_push[f] & w_full[f] &
                           ~(o_setipnum_valid[f] & i_setipnum_ready[f]);

        imsic_setipnum_fifo #(.DEPTH(FIFO_DEPTH), .W(SRC_W)) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[f]),
            .i_data  (w_id[SRC_W-1:0]),
            .i_ready (i_setipnum_ready[f]),
            .o_data  (o_setipnum[f]),
            .o_valid (o_setipnum_valid[f]),
            .o_full  (w_full[f])
        );
    end

`ifdef IMSIC_SETIPNUM_DROP_CNT_EN
    logic [15:0]   r_cnt [NF];
    logic [NF-1:0] w_clr;

    assign w_clr = {NF{i_en & i_we & (w_off == 12'h008)}} & w_hit;

    // Saturating per-file drop counters; a clear racing a drop keeps the drop.
    always_ff @(posedge i_clk) begin
        for (int f = 0; f < NF; f++) begin
            if (i_rst)                                r_cnt[f] <= '0;
            else if (w_clr[f])                        r_cnt[f] <= w_drop[f] ? 16'd1 : 16'd0;
            else if (w_drop[f] && r_cnt[f] != 16'hFFFF) r_cnt[f] <= r_cnt[f] + 16'd1;
        end
    end

    // Read mux: only offset 0x008 of a decoded page returns data.
    always_comb begin
        w_rdata_nxt = '0;
        if (w_off == 12'h008) begin
            for (int f = 0; f < NF; f++)
                if (w_hit[f]) w_rdata_nxt = {16'b0, r_cnt[f]};
        end
    end
`else
    assign w_rdata_nxt = '0;
`endif

    // Registered read response and drop pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? w_rdata_nxt : 32'd0;
            r_drop   <= |w_drop;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_drop   = r_drop;
endmodule

// File: tb/tb_imsic_setipnum_queue.sv
// Scoreboard bench: 2 harts x (M, S, VS1) = 6 files, NR_SRC=64, depth 4.
module tb_imsic_setipnum_queue;
    localparam int NF = 6;
    localparam int SW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, we;
    logic [31:0]       addr, wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [NF-1:0][SW-1:0] sip;
    logic [NF-1:0]     sip_v;
    logic [NF-1:0]     rdy;
    logic              drop;

    int n_cmp = 0;
    int n_bad = 0;
    int drops_seen = 0;
    int drops_exp  = 0;
    int exp_q [NF][$];
    logic [31:0] rd_q [$];
`ifdef IMSIC_SETIPNUM_DROP_CNT_EN
    localparam logic [31:0] CNT3 = 32'd3;
`else
    localparam logic [31:0] CNT3 = 32'd0;
`endif

    imsic_setipnum_queue #(
        .NR_IMSICS(2), .NR_VS_FILES_PER_IMSIC(1), .NR_SRC(64), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata), .o_rvalid(rvalid),
        .o_setipnum(sip), .o_setipnum_valid(sip_v),
        .i_setipnum_ready(rdy), .o_drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Each task consumes one clock; inputs change 1 time unit after posedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        en = 1'b1; we = 1'b0; addr = a;
        rd_q.push_back(e);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handshake and read response.
    always @(negedge clk) begin
        if (!rst) begin
            for (int f = 0; f < NF; f++) begin
                if (sip_v[f] && rdy[f]) begin
                    if (exp_q[f].size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_valid file %0d: got id %0d expected none", f, sip[f]);
                    end else begin
                        chk($sformatf("setipnum[%0d]", f), 32'(sip[f]), 32'(exp_q[f].pop_front()));
                    end
                end
            end
            if (drop) drops_seen++;
            if (rvalid) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rvalid: got 0x%0h expected none", rdata);
                end else begin
                    chk("rdata", rdata, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0; rdy = '1;
        idle(2);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_setipnum", 32'(sip), 32'd0);
        chk("rst_valid", 32'(sip_v), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single LE write to hart0 M: valid for exactly one cycle.
        exp_q[0].push_back(5);
        wr(32'h24000000, 32'h5);
        chk("lat_valid0", 32'(sip_v), 32'h01);
        idle(1);
        chk("lat_valid0_gone", 32'(sip_v), 32'h00);

        // BE write to hart1 VS1 (file 5).
        exp_q[5].push_back(10);
        wr(32'h28003004, 32'h0A000000);
        chk("be_valid_only5", 32'(sip_v), 32'h20);
        idle(1);

        // Invalid identities / offsets / pages: nothing queued, no drop.
        wr(32'h24000000, 32'h0);
        wr(32'h24000000, 32'd64);
        wr(32'h24000000, 32'hFFFFFFFF);
        wr(32'h2400000C, 32'h7);
        wr(32'h24002000, 32'h7);
        wr(32'h28004000, 32'h7);
        chk("invalid_no_valid", 32'(sip_v), 32'h00);
        chk("invalid_no_drop", 32'(drop), 32'd0);

        // Fill hart0 S (file 1) with ready low; fifth write drops.
        rdy = 6'b111101;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q[1].push_back(i);
            wr(32'h28000000, 32'(i));
        end
        drops_exp += 1;
        chk("full_drop_pulse", 32'(drop), 32'd1);
        rdy = '1;
        idle(1);
        chk("drop_one_cycle", 32'(drop), 32'd0);
        idle(3);
        chk("drained_f1", 32'(sip_v), 32'h00);

        // Full FIFO, pop and push in the same cycle: no drop, new entry last.
        rdy = 6'b111101;
        for (int i = 11; i <= 14; i++) begin
            exp_q[1].push_back(i);
            wr(32'h28000000, 32'(i));
        end
        rdy = '1;
        exp_q[1].push_back(15);
        wr(32'h28000000, 32'd15);
        chk("full_pushpop_no_drop", 32'(drop), 32'd0);
        idle(5);
        chk("drained_f1_b", 32'(sip_v), 32'h00);

        // Reset flushes queued identities.
        rdy = 6'b111110;
        wr(32'h24000000, 32'd21);
        wr(32'h24000000, 32'd22);
        wr(32'h24000000, 32'd23);
        chk("queued_before_rst", 32'(sip_v), 32'h01);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("flush_valid", 32'(sip_v), 32'h00);
        rdy = '1;
        idle(1);

        // Three drops on hart0 S, then counter read/clear.
        rdy = 6'b111101;
        for (int i = 31; i <= 37; i++) begin
            if (i <= 34) exp_q[1].push_back(i);
            wr(32'h28000000, 32'(i));
        end
        drops_exp += 3;
        rd(32'h28000008, CNT3);
        rd(32'h28002008, 32'd0);
        wr(32'h28000008, 32'hDEAD);
        rd(32'h28000008, 32'd0);
        rd(32'h24000000, 32'd0);
        rd(32'h30000000, 32'd0);
        rdy = '1;
        idle(6);

        chk("drop_total", 32'(drops_seen), 32'(drops_exp));
        chk("end_valid", 32'(sip_v), 32'h00);
        for (int f = 0; f < NF; f++)
            chk($sformatf("leftover_q%0d", f), 32'(exp_q[f].size()), 32'd0);
        chk("leftover_rd", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
